// File: rtl/load_store_unit_if.sv
// Bus between the core's execute stage, the load/store unit and the 64-bit word data memory.
// The slave modport is the LSU's view; master is the core-plus-memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_writeData;
  logic              mem_writeEn;
  logic [63:0]       mem_readData;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_writeData, mem_writeEn
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_writeData, mem_writeEn
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligned 1/2/4/8-byte little-endian accesses to a 64-bit word memory.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module load_store_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [2:0]        off_q;
  logic [63:0]       wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [63:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [63:0]       mem_writeData_q;
  logic              mem_writeEn_q;

  // Address bits above the memory range wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[63:ADDR_W+3];

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      2'b11:   misaligned = |a[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] bm;
    case (size)
      2'b00:   bm = 8'h01;
      2'b01:   bm = 8'h03;
      2'b10:   bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    bm = bm << off;
    for (int i = 0; i < 8; i++) lane_mask[8*i +: 8] = {8{bm[i]}};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [1:0] size, input logic [2:0] off);
    logic [63:0] m;
    m     = lane_mask(size, off);
    merge = (old & ~m) | ((wd << {off, 3'b000}) & m);
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] word, input logic [1:0] size,
                                         input logic [2:0] off, input logic uns);
    logic [63:0] f;
    f = word >> {off, 3'b000};
    case (size)
      2'b00:   extend = uns ? {56'd0, f[7:0]}  : {{56{f[7]}},  f[7:0]};
      2'b01:   extend = uns ? {48'd0, f[15:0]} : {{48{f[15]}}, f[15:0]};
      2'b10:   extend = uns ? {32'd0, f[31:0]} : {{32{f[31]}}, f[31:0]};
      default: extend = f;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      size_q          <= 2'b00;
      uns_q           <= 1'b0;
      off_q           <= 3'd0;
      wdata_q         <= 64'd0;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 64'd0;
      rsp_err_q       <= 1'b0;
      mem_address_q   <= '0;
      mem_writeData_q <= 64'd0;
      mem_writeEn_q   <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 64'd0;
      rsp_err_q     <= 1'b0;
      mem_writeEn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_address_q   <= '0;
          mem_writeData_q <= 64'd0;
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            off_q       <= bus.req_addr[2:0];
            wdata_q     <= bus.req_wdata;
            if (misaligned(bus.req_size, bus.req_addr[2:0])) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              mem_address_q <= bus.req_addr[ADDR_W+2:3];
              // A full double store needs no read: go straight to the write.
              if (bus.req_we && bus.req_size == 2'b11) begin
                state_q         <= WR;
                mem_writeEn_q   <= 1'b1;
                mem_writeData_q <= bus.req_wdata;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q         <= WR;
            mem_writeEn_q   <= 1'b1;
            mem_writeData_q <= merge(bus.mem_readData, wdata_q, size_q, off_q);
          end else begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= extend(bus.mem_readData, size_q, off_q, uns_q);
          end
        end
        WR: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
        end
        RSP: begin
          state_q         <= IDLE;
          req_ready_q     <= 1'b1;
          mem_address_q   <= '0;
          mem_writeData_q <= 64'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writeData = mem_writeData_q;
  assign bus.mem_writeEn   = mem_writeEn_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a queue of expected responses is filled at issue time
// and drained by an independent response monitor; a behavioural memory sits on the mem_* side.
module tb_load_store_unit;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [63:0] mem [DEPTH] = '{0: 64'h0123456789ABCDEF, default: 64'h0};
  int wr_count = 0;
  always @(posedge clk) begin
    if (bus.mem_writeEn) begin
      mem[bus.mem_address] <= bus.mem_writeData;
      wr_count             <= wr_count + 1;
    end
  end
  assign bus.mem_readData = mem[bus.mem_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Response monitor: every rsp_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: rdata=%h err=%0d at cycle %0d, none expected",
                 bus.rsp_rdata, bus.rsp_err, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || cyc != e.cyc) begin
          fails++;
          $display("FAIL %s: got rdata=%h err=%0d cycle=%0d, want rdata=%h err=%0d cycle=%0d",
                   e.name, bus.rsp_rdata, bus.rsp_err, cyc, e.rdata, e.err, e.cyc);
        end else begin
          $display("[TB] %s: rdata=%h err=%0d cycle=%0d ok", e.name, bus.rsp_rdata, bus.rsp_err, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end else begin
      $display("[TB] %s: %h ok", name, act);
    end
  endtask

  // Called at a negedge; lat = index of the edge after which the response appears (accept = 0).
  task automatic issue(input string name, input bit we, input bit [1:0] size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input bit exp_err, input int lat);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready: got req_ready=0, want 1 within 50 cycles", name);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    exp_q.push_back('{exp_rdata, exp_err, cyc + 1 + lat, name});
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  int wr_before;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",     {63'd0, bus.req_ready},   64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid},   64'd0);
    check("rst_rsp_err",   {63'd0, bus.rsp_err},     64'd0);
    check("rst_writeEn",   {63'd0, bus.mem_writeEn}, 64'd0);
    check("rst_rdata",     bus.rsp_rdata,            64'd0);
    check("rst_address",   {56'd0, bus.mem_address}, 64'd0);
    check("rst_writeData", bus.mem_writeData,        64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {63'd0, bus.req_ready}, 64'd1);

    // Reset while a byte store sits in RD: outputs clear at once, no write happens.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'h18; bus.req_wdata = 64'hEE;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rd_address", {56'd0, bus.mem_address}, 64'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_ready",   {63'd0, bus.req_ready},   64'd0);
    check("midrst_address", {56'd0, bus.mem_address}, 64'd0);
    check("midrst_writeEn", {63'd0, bus.mem_writeEn}, 64'd0);
    check("midrst_valid",   {63'd0, bus.rsp_valid},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", {63'd0, bus.req_ready}, 64'd1);
    check("midrst_no_write",    mem[3], 64'd0);
    check("midrst_wr_count",    64'(wr_count), 64'd0);

    // Double store then double load
    issue("SD_0x18", 1, 2'b11, 0, 64'h18, 64'h1122334455667788, 64'd0, 0, 1);
    issue("LD_0x18", 0, 2'b11, 0, 64'h18, 64'd0, 64'h1122334455667788, 0, 1);
    drain();
    check("word3_after_SD", mem[3], 64'h1122334455667788);
    check("SD_one_write", 64'(wr_count), 64'd1);

    // Byte store with junk upper data, then unsigned/signed byte loads
    issue("SB_0x1D",  1, 2'b00, 0, 64'h1D, 64'h55555555555555AB, 64'd0, 0, 2);
    issue("LBU_0x1D", 0, 2'b00, 1, 64'h1D, 64'd0, 64'h00000000000000AB, 0, 1);
    issue("LB_0x1D",  0, 2'b00, 0, 64'h1D, 64'd0, 64'hFFFFFFFFFFFFFFAB, 0, 1);
    drain();
    check("word3_after_SB", mem[3], 64'h1122AB4455667788);

    // Half store, then a signed word load that sees the new sign bit
    issue("SH_0x1A", 1, 2'b01, 0, 64'h1A, 64'hFFFF000000008001, 64'd0, 0, 2);
    issue("LW_0x18", 0, 2'b10, 0, 64'h18, 64'd0, 64'hFFFFFFFF80017788, 0, 1);
    drain();
    check("word3_after_SH", mem[3], 64'h1122AB4480017788);

    // Misaligned requests: error after accept edge, no memory access
    wr_before = wr_count;
    issue("LW_0x1E_mis", 0, 2'b10, 0, 64'h1E, 64'd0, 64'd0, 1, 0);
    issue("SH_0x13_mis", 1, 2'b01, 0, 64'h13, 64'h1234, 64'd0, 1, 0);
    issue("SD_0x0C_mis", 1, 2'b11, 0, 64'h0C, 64'hCAFE, 64'd0, 1, 0);
    drain();
    check("mis_no_writes", 64'(wr_count - wr_before), 64'd0);
    check("mis_word1", mem[1], 64'd0);
    check("mis_word2", mem[2], 64'd0);
    check("mis_word3", mem[3], 64'h1122AB4480017788);

    // Address wrap: byte 8*DEPTH+4 lands in the upper half of word 0
    issue("SW_wrap",   1, 2'b10, 0, 64'(8*DEPTH + 4), 64'h00000000DEADBEEF, 64'd0, 0, 2);
    issue("LWU_wrap",  0, 2'b10, 1, 64'(8*DEPTH + 4), 64'd0, 64'h00000000DEADBEEF, 0, 1);
    issue("LH_0x06",   0, 2'b01, 0, 64'h6, 64'd0, 64'hFFFFFFFFFFFFDEAD, 0, 1);
    issue("LHU_0x02",  0, 2'b01, 1, 64'h2, 64'd0, 64'h00000000000089AB, 0, 1);
    drain();
    check("word0_after_wrap", mem[0], 64'hDEADBEEF89ABCDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
